// File: rtl/aurora_tx_pkg.sv
// Shared types and constants for the Aurora Tx block scheduler.
package aurora_tx_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        SEL_CC   = 2'd0,
        SEL_REG  = 2'd1,
        SEL_DATA = 2'd2,
        SEL_IDLE = 2'd3
    } slot_sel_t;

    localparam logic [1:0]  SYNC_DATA      = 2'b01;
    localparam logic [1:0]  SYNC_CTRL      = 2'b10;
    localparam logic [63:0] IDLE_BLOCK_DEF = 64'h7800_0000_0000_0000;
    localparam logic [63:0] CC_BLOCK_DEF   = 64'h7880_0000_0000_0000;
    localparam logic [7:0]  REG_BTF_DEF    = 8'hD2;

endpackage

// File: rtl/aurora_tx_block_scheduler_arbiter.sv
// Per-slot priority select: CC over register readback over user data, else idle.
// Purely combinational; zero latency, no backpressure of its own.
module tx_slot_arbiter
    import aurora_tx_pkg::*;
(
    input  logic      cc_pending_i,
    input  logic      reg_req_i,
    input  logic      data_valid_i,
    output slot_sel_t sel_o
);

    always_comb begin
        sel_o = SEL_IDLE;
        if (cc_pending_i) begin
            sel_o = SEL_CC;
        end else if (reg_req_i) begin
            sel_o = SEL_REG;
        end else if (data_valid_i) begin
            sel_o = SEL_DATA;
        end
    end

endmodule

// File: rtl/aurora_tx_block_scheduler.sv
// Feeds one 64-bit block per gearbox slot: link-init idles, then CC/register/data/idle.
// Block registered on the slot edge; data_ready/reg_ack are same-cycle strobes gated by slot.
module aurora_tx_block_scheduler
    import aurora_tx_pkg::*;
#(
    parameter int unsigned INIT_BLOCKS = 64,
    parameter int unsigned CC_PERIOD   = 1024,
    parameter logic [63:0] IDLE_WORD   = IDLE_BLOCK_DEF,
    parameter logic [63:0] CC_WORD     = CC_BLOCK_DEF,
    parameter logic [7:0]  REG_BTF     = REG_BTF_DEF
) (
    input  logic        clk40,
    input  logic        rst,
    input  logic        gearbox_rdy,
    input  logic        data_next,
    input  logic        data_valid,
    input  logic [63:0] data_in,
    output logic        data_ready,
    input  logic        reg_req,
    input  logic [55:0] reg_data,
    output logic        reg_ack,
    output logic [63:0] tx_data,
    output logic [1:0]  tx_sync,
    output logic        tx_en,
    output logic        link_up,
    output logic [1:0]  state_o
);

    localparam logic [15:0] INIT_LAST = 16'(INIT_BLOCKS - 1);
    localparam logic [15:0] CC_LAST   = 16'(CC_PERIOD - 1);

    sched_state_t state_q, state_d;
    logic [15:0]  init_cnt_q, init_cnt_d;
    logic [15:0]  cc_cnt_q, cc_cnt_d;
    logic         cc_pending_q, cc_pending_d;
    logic [63:0]  tx_data_q, tx_data_d;
    logic [1:0]   tx_sync_q, tx_sync_d;
    logic         slot;
    logic         cc_due;
    slot_sel_t    slot_sel;

    assign slot = gearbox_rdy & data_next;

    tx_slot_arbiter u_arb (
        .cc_pending_i (cc_pending_q),
        .reg_req_i    (reg_req),
        .data_valid_i (data_valid),
        .sel_o        (slot_sel)
    );

    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        cc_cnt_d     = cc_cnt_q;
        cc_pending_d = cc_pending_q;
        tx_data_d    = tx_data_q;
        tx_sync_d    = tx_sync_q;
        data_ready   = 1'b0;
        reg_ack      = 1'b0;
        cc_due       = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (gearbox_rdy) begin
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                if (!gearbox_rdy) begin
                    state_d      = ST_WAIT;
                    init_cnt_d   = 16'd0;
                    cc_cnt_d     = 16'd0;
                    cc_pending_d = 1'b0;
                end else if (slot) begin
                    tx_data_d = IDLE_WORD;
                    tx_sync_d = SYNC_CTRL;
                    if (init_cnt_q == INIT_LAST) begin
                        state_d    = ST_RUN;
                        init_cnt_d = 16'd0;
                    end else begin
                        init_cnt_d = init_cnt_q + 16'd1;
                    end
                end
            end

            ST_RUN: begin
                if (!gearbox_rdy) begin
                    state_d      = ST_WAIT;
                    init_cnt_d   = 16'd0;
                    cc_cnt_d     = 16'd0;
                    cc_pending_d = 1'b0;
                end else if (slot) begin
                    // The CC slot itself is counted, so CCs land exactly CC_PERIOD apart.
                    cc_due   = (cc_cnt_q == CC_LAST);
                    cc_cnt_d = cc_due ? 16'd0 : cc_cnt_q + 16'd1;

                    case (slot_sel)
                        SEL_CC: begin
                            tx_data_d = CC_WORD;
                            tx_sync_d = SYNC_CTRL;
                        end
                        SEL_REG: begin
                            tx_data_d = {REG_BTF, reg_data};
                            tx_sync_d = SYNC_CTRL;
                            reg_ack   = 1'b1;
                        end
                        SEL_DATA: begin
                            tx_data_d  = data_in;
                            tx_sync_d  = SYNC_DATA;
                            data_ready = 1'b1;
                        end
                        default: begin
                            tx_data_d = IDLE_WORD;
                            tx_sync_d = SYNC_CTRL;
                        end
                    endcase

                    // A CC falling due while one is still owed merges into it.
                    cc_pending_d = (cc_pending_q && (slot_sel != SEL_CC)) || cc_due;
                end
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk40) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            init_cnt_q   <= 16'd0;
            cc_cnt_q     <= 16'd0;
            cc_pending_q <= 1'b0;
            tx_data_q    <= 64'd0;
            tx_sync_q    <= 2'b00;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            cc_cnt_q     <= cc_cnt_d;
            cc_pending_q <= cc_pending_d;
            tx_data_q    <= tx_data_d;
            tx_sync_q    <= tx_sync_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_sync = tx_sync_q;
    assign tx_en   = slot;
    assign link_up = (state_q == ST_RUN);
    assign state_o = state_q;

endmodule

// File: tb/tb_aurora_tx_block_scheduler.sv
// Directed bench for aurora_tx_block_scheduler with INIT_BLOCKS=4, CC_PERIOD=8.
module tb_aurora_tx_block_scheduler;

    localparam logic [63:0] IDLE_W = 64'h7800_0000_0000_0000;
    localparam logic [63:0] CC_W   = 64'h7880_0000_0000_0000;
    localparam logic [63:0] REG_W  = 64'hD212_3456_789A_BCDE;
    localparam logic [1:0]  S_DAT  = 2'b01;
    localparam logic [1:0]  S_CTL  = 2'b10;

    logic        clk40 = 1'b0;
    logic        rst;
    logic        gearbox_rdy;
    logic        data_next;
    logic        data_valid;
    logic [63:0] data_in;
    logic        data_ready;
    logic        reg_req;
    logic [55:0] reg_data;
    logic        reg_ack;
    logic [63:0] tx_data;
    logic [1:0]  tx_sync;
    logic        tx_en;
    logic        link_up;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_d;

    aurora_tx_block_scheduler #(
        .INIT_BLOCKS (4),
        .CC_PERIOD   (8)
    ) dut (
        .clk40       (clk40),
        .rst         (rst),
        .gearbox_rdy (gearbox_rdy),
        .data_next   (data_next),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .data_ready  (data_ready),
        .reg_req     (reg_req),
        .reg_data    (reg_data),
        .reg_ack     (reg_ack),
        .tx_data     (tx_data),
        .tx_sync     (tx_sync),
        .tx_en       (tx_en),
        .link_up     (link_up),
        .state_o     (state_o)
    );

    always #5 clk40 = ~clk40;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    // One slot followed by a gap cycle; the bench acts as data producer and register requester.
    task automatic do_slot(output logic rdy, output logic ack);
        data_next = 1'b1;
        #1;
        rdy = data_ready;
        ack = reg_ack;
        chk("tx_en", {63'd0, tx_en}, 64'd1);
        step();
        data_next = 1'b0;
        if (ack) reg_req = 1'b0;
        if (rdy) data_in = data_in + 64'd1;
        step();
    endtask

    task automatic exp_slot(input string tag, input logic [63:0] d, input logic [1:0] s,
                            input logic r, input logic a);
        logic rdy, ack;
        do_slot(rdy, ack);
        chk({tag, "_rdy"},  {63'd0, rdy}, {63'd0, r});
        chk({tag, "_ack"},  {63'd0, ack}, {63'd0, a});
        chk({tag, "_data"}, tx_data, d);
        chk({tag, "_sync"}, {62'd0, tx_sync}, {62'd0, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; gearbox_rdy = 1'b0; data_next = 1'b0; data_valid = 1'b0;
        data_in = 64'd0; reg_req = 1'b0; reg_data = 56'h12_3456_789A_BCDE;
        step(); step();

        chk("rst_tx_data", tx_data, 64'd0);
        chk("rst_tx_sync", {62'd0, tx_sync}, 64'd0);
        chk("rst_link_up", {63'd0, link_up}, 64'd0);
        chk("rst_state",   {62'd0, state_o}, 64'd0);
        chk("rst_reg_ack", {63'd0, reg_ack}, 64'd0);
        chk("rst_tx_en",   {63'd0, tx_en}, 64'd0);
        rst = 1'b0;
        step();
        chk("wait_state", {62'd0, state_o}, 64'd0);

        // Link init: 4 idles, then RUN
        gearbox_rdy = 1'b1;
        step();
        chk("init_state", {62'd0, state_o}, 64'd1);
        for (int i = 0; i < 3; i++) exp_slot("init_idle", IDLE_W, S_CTL, 1'b0, 1'b0);
        chk("init_link_low", {63'd0, link_up}, 64'd0);
        exp_slot("init_idle4", IDLE_W, S_CTL, 1'b0, 1'b0);
        chk("run_link_up", {63'd0, link_up}, 64'd1);
        chk("run_state",   {62'd0, state_o}, 64'd2);

        // First RUN slot idle, then data 0..6, CC, data 7..13, CC, data 14
        exp_slot("run_idle", IDLE_W, S_CTL, 1'b0, 1'b0);
        data_valid = 1'b1;
        data_in = 64'd0;
        exp_d = 64'd0;
        for (int k = 1; k <= 17; k++) begin
            if (k % 8 == 0) begin
                exp_slot("cc", CC_W, S_CTL, 1'b0, 1'b0);
            end else begin
                exp_slot("data", exp_d, S_DAT, 1'b1, 1'b0);
                exp_d = exp_d + 64'd1;
            end
        end

        // Register block pre-empts held user data
        reg_req = 1'b1;
        exp_slot("reg", REG_W, S_CTL, 1'b0, 1'b1);
        exp_slot("after_reg", 64'd15, S_DAT, 1'b1, 1'b0);
        exp_d = 64'd16;
        for (int k = 0; k < 4; k++) begin
            exp_slot("data_b", exp_d, S_DAT, 1'b1, 1'b0);
            exp_d = exp_d + 64'd1;
        end

        // CC owed and register request on the same slot
        reg_req = 1'b1;
        exp_slot("cc_first",   CC_W,   S_CTL, 1'b0, 1'b0);
        exp_slot("reg_second", REG_W,  S_CTL, 1'b0, 1'b1);
        exp_slot("data_third", 64'd20, S_DAT, 1'b1, 1'b0);

        // gearbox_rdy drop with a register request left pending
        reg_req = 1'b1;
        gearbox_rdy = 1'b0;
        step();
        chk("drop_state",   {62'd0, state_o}, 64'd0);
        chk("drop_link",    {63'd0, link_up}, 64'd0);
        chk("drop_hold_d",  tx_data, 64'd20);
        chk("drop_hold_s",  {62'd0, tx_sync}, {62'd0, S_DAT});
        step(); step();
        gearbox_rdy = 1'b1;
        step();
        chk("reinit_state", {62'd0, state_o}, 64'd1);
        for (int i = 0; i < 4; i++) exp_slot("reinit_idle", IDLE_W, S_CTL, 1'b0, 1'b0);
        chk("reinit_link", {63'd0, link_up}, 64'd1);
        exp_slot("reg_after_reinit", REG_W, S_CTL, 1'b0, 1'b1);
        exp_d = 64'd21;
        for (int k = 1; k <= 7; k++) begin
            exp_slot("data_c", exp_d, S_DAT, 1'b1, 1'b0);
            exp_d = exp_d + 64'd1;
        end
        exp_slot("cc_restart", CC_W, S_CTL, 1'b0, 1'b0);
        exp_slot("data_c_end", 64'd28, S_DAT, 1'b1, 1'b0);

        // Reset mid-RUN with data held
        rst = 1'b1;
        step();
        rst = 1'b0;
        data_next = 1'b1;
        #1;
        chk("mrst_tx_sync", {62'd0, tx_sync}, 64'd0);
        chk("mrst_tx_data", tx_data, 64'd0);
        chk("mrst_ready",   {63'd0, data_ready}, 64'd0);
        chk("mrst_ack",     {63'd0, reg_ack}, 64'd0);
        chk("mrst_state",   {62'd0, state_o}, 64'd0);
        chk("mrst_link",    {63'd0, link_up}, 64'd0);
        data_next = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
